// File: rtl/forward_scoreboard_if.sv
// Bundle of issue-side inputs and forwarding results between decode/issue and the scoreboard.
// master: decode/issue side, which drives the issue fields and reads fwd_sel/stall/stall_cnt.
// slave: the scoreboard, which reads the issue fields and drives the results.
interface forward_scoreboard_if #(
    parameter int NSRC  = 2,
    parameter int DEPTH = 3,
    parameter int REG_W = 5,
    parameter int CNT_W = 16,
    parameter int SEL_W = $clog2(DEPTH+1)
);
    logic                    adv;
    logic                    issue_valid;
    logic                    issue_wen;
    logic                    issue_load;
    logic [REG_W-1:0]        issue_wsel;
    logic [NSRC*REG_W-1:0]   src_sel;
    logic [DEPTH-1:0]        flush_mask;
    logic [NSRC*SEL_W-1:0]   fwd_sel;
    logic                    stall;
    logic [CNT_W-1:0]        stall_cnt;

    modport master (
        output adv, issue_valid, issue_wen, issue_load, issue_wsel, src_sel, flush_mask,
        input  fwd_sel, stall, stall_cnt
    );

    modport slave (
        input  adv, issue_valid, issue_wen, issue_load, issue_wsel, src_sel, flush_mask,
        output fwd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/forward_scoreboard.sv
// Purpose: tracks in-flight register writes in a DEPTH-slot shift table and picks a forward source per operand.
// Latency: fwd_sel/stall are combinational from the table; an issue at edge N is visible from cycle N+1.
// Backpressure: raises stall on a load-use hazard (youngest match is a load not yet forwardable); not gated by adv.
// Ports: clk_i/rst_i (sync, active-high), sb_if.slave carries adv, issue_*, src_sel, flush_mask in and
//        fwd_sel (0 = regfile, i+1 = slot i), stall, stall_cnt (saturating stall-cycle count) out.
module forward_scoreboard #(
    parameter int NSRC     = 2,
    parameter int DEPTH    = 3,
    parameter int REG_W    = 5,
    parameter int LOAD_RDY = 2,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(DEPTH+1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    forward_scoreboard_if.slave   sb_if
);

    typedef struct packed {
        logic             vld;
        logic [REG_W-1:0] wsel;
        logic             is_load;
    } entry_t;

    entry_t               tbl_q [DEPTH];
    entry_t               tbl_d [DEPTH];
    entry_t               issue_ent;
    logic                 issue_take;
    logic [CNT_W-1:0]     stall_cnt_q;

    logic [NSRC-1:0]        src_hit;
    logic [NSRC-1:0]        src_ld;
    logic [NSRC*SEL_W-1:0]  fwd_sel_c;
    logic                   stall_c;

    // Youngest-match search: the first valid slot (lowest index) with a matching
    // destination wins, so older writers of the same register are shadowed.
    always_comb begin
        fwd_sel_c = '0;
        src_hit   = '0;
        src_ld    = '0;
        for (int k = 0; k < NSRC; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!src_hit[k] && (sb_if.src_sel[k*REG_W +: REG_W] != '0) &&
                    tbl_q[i].vld && (tbl_q[i].wsel == sb_if.src_sel[k*REG_W +: REG_W])) begin
                    src_hit[k]                   = 1'b1;
                    fwd_sel_c[k*SEL_W +: SEL_W]  = SEL_W'(i + 1);
                    // Load data only exists from slot LOAD_RDY onward.
                    src_ld[k]                    = tbl_q[i].is_load && (i < LOAD_RDY);
                end
            end
        end
        stall_c = sb_if.issue_valid && (|src_ld);
    end

    // A stalled instruction must not enter slot 0; a bubble goes in instead.
    // Writes to r0 are never tracked since r0 cannot hold a value.
    assign issue_take = sb_if.issue_valid && sb_if.issue_wen && !stall_c &&
                        (sb_if.issue_wsel != '0);
    assign issue_ent  = {1'b1, sb_if.issue_wsel, sb_if.issue_load};

    // Shift (when advancing) first, then flush by destination slot index.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tbl_d[i] = tbl_q[i];
        end
        if (sb_if.adv) begin
            tbl_d[0] = issue_take ? issue_ent : '0;
            for (int i = 1; i < DEPTH; i++) begin
                tbl_d[i] = tbl_q[i-1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (sb_if.flush_mask[i]) begin
                tbl_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
            // Counts every stalled edge, including held (adv=0) cycles; sticks at all-ones.
            if (stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign sb_if.fwd_sel   = fwd_sel_c;
    assign sb_if.stall     = stall_c;
    assign sb_if.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Scoreboard bench for forward_scoreboard: the driver pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares. A second instance with CNT_W=4 shares all inputs and is
// used for counter saturation.
module tb_forward_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    forward_scoreboard_if #(.NSRC(2), .DEPTH(3), .REG_W(5), .CNT_W(16)) bus  ();
    forward_scoreboard_if #(.NSRC(2), .DEPTH(3), .REG_W(5), .CNT_W(4))  sbus ();

    assign sbus.adv         = bus.adv;
    assign sbus.issue_valid = bus.issue_valid;
    assign sbus.issue_wen   = bus.issue_wen;
    assign sbus.issue_load  = bus.issue_load;
    assign sbus.issue_wsel  = bus.issue_wsel;
    assign sbus.src_sel     = bus.src_sel;
    assign sbus.flush_mask  = bus.flush_mask;

    forward_scoreboard #(.NSRC(2), .DEPTH(3), .REG_W(5), .LOAD_RDY(2), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb_if (bus)
    );

    forward_scoreboard #(.NSRC(2), .DEPTH(3), .REG_W(5), .LOAD_RDY(2), .CNT_W(4)) dut_sat (
        .clk_i (clk),
        .rst_i (rst),
        .sb_if (sbus)
    );

    // -1 in a field means "not checked this cycle".
    typedef struct {
        int fwd0;
        int fwd1;
        int stl;
        int cnt;
        int scnt;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string nm, input string fld, input int act, input int expv);
        if (expv >= 0) begin
            n_tests++;
            if (act != expv) begin
                n_fail++;
                $display("FAIL %s.%s: got %0d, expected %0d at %0t", nm, fld, act, expv, $time);
            end
        end
    endtask

    // Monitor: whenever an expectation is pending, compare against the DUT outputs mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, "fwd0",  int'(bus.fwd_sel[1:0]),  e.fwd0);
            chk(nm, "fwd1",  int'(bus.fwd_sel[3:2]),  e.fwd1);
            chk(nm, "stall", int'(bus.stall),         e.stl);
            chk(nm, "cnt",   int'(bus.stall_cnt),     e.cnt);
            chk(nm, "scnt",  int'(sbus.stall_cnt),    e.scnt);
        end
    end

    // Apply one cycle of inputs, queue the expected outputs for that cycle, advance to after the edge.
    task automatic step(input logic a, input logic iv, input logic wen, input logic ld,
                        input int ws, input int s0, input int s1, input int fl,
                        input string nm, input int f0, input int f1, input int st,
                        input int cnt, input int sc);
        exp_t e;
        bus.adv         = a;
        bus.issue_valid = iv;
        bus.issue_wen   = wen;
        bus.issue_load  = ld;
        bus.issue_wsel  = ws[4:0];
        bus.src_sel     = {s1[4:0], s0[4:0]};
        bus.flush_mask  = fl[2:0];
        e.fwd0 = f0; e.fwd1 = f1; e.stl = st; e.cnt = cnt; e.scnt = sc;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        bus.adv         = 1'($urandom);
        bus.issue_valid = 1'($urandom);
        bus.issue_wen   = 1'($urandom);
        bus.issue_load  = 1'($urandom);
        bus.issue_wsel  = 5'($urandom);
        bus.src_sel     = 10'($urandom);
        bus.flush_mask  = 3'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rand_inputs();
        @(posedge clk); #1;
        rand_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.adv = 0; bus.issue_valid = 0; bus.issue_wen = 0; bus.issue_load = 0;
        bus.issue_wsel = '0; bus.src_sel = '0; bus.flush_mask = '0;

        // 1: reset with random inputs; table empty afterwards, so any sources give 0 and no stall.
        do_reset();
        step(1,1,0,0, 0, 7,13, 0, "reset", 0,0,0,0,0);

        // 2: ALU chain on r5. Issuer reading its own destination does not forward from itself.
        do_reset();
        step(1,1,1,0, 5, 5, 0, 0, "alu_self",  0,0,0,0,0);
        step(1,1,0,0, 0, 5, 0, 0, "alu_slot0", 1,0,0,0,0);
        step(1,0,0,0, 0, 5, 5, 0, "alu_slot1", 2,2,0,0,0);
        step(1,1,0,0, 0, 0, 5, 0, "alu_slot2", 0,3,0,0,0);
        step(1,1,0,0, 0, 5, 5, 0, "alu_gone",  0,0,0,0,0);

        // 3: load-use on r7: two stall cycles, then forward from slot 2.
        do_reset();
        step(1,1,1,1, 7, 0, 0, 0, "ld_issue",  0,0,0,0,0);
        step(1,1,0,0, 0, 7, 0, 0, "ld_stall0", 1,0,1,0,0);
        step(1,1,0,0, 0, 7, 0, 0, "ld_stall1", 2,0,1,1,1);
        step(1,1,0,0, 0, 7, 0, 0, "ld_fwd",    3,0,0,2,2);

        // 4: load r4 shadowed by a younger ALU write to r4; r0 writes never tracked.
        do_reset();
        step(1,1,1,1, 4, 0, 0, 0, "sh_load",  0,0,0,0,0);
        step(1,1,1,0, 4, 1, 0, 0, "sh_addi",  0,0,0,0,0);
        step(1,1,1,0, 0, 4, 4, 0, "sh_read",  1,1,0,0,0);
        step(1,1,0,0, 0, 0, 4, 0, "sh_r0",    0,2,0,0,0);

        // 5: flush of the issue slot, flush of a shifted slot, then a frozen table with adv=0.
        do_reset();
        step(1,1,1,1, 9, 0, 0, 1, "fl_issue",  0,0,0,0,0);
        step(1,1,1,0,10, 9, 0, 0, "fl_gone",   0,0,0,0,0);
        step(1,0,0,0, 0,10, 0, 2, "fl_r10",    1,0,0,0,0);
        step(1,0,0,0, 0,10, 0, 0, "fl_slot1",  0,0,0,0,0);
        step(1,1,1,1, 9, 0, 0, 0, "hold_ld",   0,0,0,0,0);
        for (int j = 0; j < 4; j++)
            step(0,1,0,0, 0, 9, 0, 0, "hold", 1,0,1,j,j);
        step(1,1,0,0, 0, 9, 0, 0, "hold_rel0", 1,0,1,4,4);
        step(1,1,0,0, 0, 9, 0, 0, "hold_rel1", 2,0,1,5,5);
        step(1,1,0,0, 0, 9, 0, 0, "hold_fwd",  3,0,0,6,6);

        // 6: long held stall; the 4-bit counter saturates at 15, the 16-bit one keeps counting.
        do_reset();
        step(1,1,1,1, 3, 0, 0, 0, "sat_ld", 0,0,0,0,0);
        for (int j = 0; j < 20; j++)
            step(0,1,0,0, 0, 3, 0, 0, "sat_hold", 1,0,1,j,(j > 15) ? 15 : j);
        step(0,0,0,0, 0, 0, 0, 0, "sat_end", 0,0,0,20,15);

        @(posedge clk); #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
